resp_router: RTL

- Return path paired with the round-robin arbiter.
- Records the requester index of every transaction the arbiter issues to the shared resource.
- Routes in-order responses from that resource back to the originating requester as a one-hot valid plus data.
- Sits between the shared resource's response port and the NUM_REQUESTERS requesting units.

---
 rtl/resp_router_pkg.sv | 13 +
 rtl/resp_router_grant_id_fifo.sv | 56 +++++
 rtl/resp_router.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/resp_router_pkg.sv
// Shared types and default sizing for the response router.
// The typedefs match the default configuration below.
package resp_router_defs;

    localparam int NUM_REQUESTERS_DEF  = 4;
    localparam int MAX_OUTSTANDING_DEF = 8;
    localparam int DATA_WIDTH_DEF      = 32;
    localparam int TIMEOUT_CYCLES_DEF  = 1024;

    typedef logic [$clog2(NUM_REQUESTERS_DEF)-1:0] requester_idx_t;
    typedef logic [$clog2(MAX_OUTSTANDING_DEF+1)-1:0] outstanding_cnt_t;

endpackage

// File: rtl/resp_router_grant_id_fifo.sv
// Circular FIFO holding the requester index of each issued
// transaction.
// Ports: clk, reset (sync, active high), push/push_data,
// pop, head (oldest entry), full, empty, count.
module grant_id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap on overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/resp_router.sv
// Return path for the round-robin arbiter: records the
// requester of every issued transaction and routes in-order
// responses back as a one-hot strobe plus data.
// Ports: clk, reset (sync, active high); issue_en,
// issue_grant_oh, issue_ready; resp_valid, resp_data,
// resp_ready; req_resp_valid_oh, req_resp_data;
// outstanding_count, protocol_error, timeout.
// Optional: define RESP_ROUTER_TIMEOUT_EN to enable the
// response age counter; otherwise timeout is tied to 0.
module resp_router
    import resp_router_defs::*;
#(
    parameter int NUM_REQUESTERS  = NUM_REQUESTERS_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 issue_en,
    input  logic [NUM_REQUESTERS-1:0]            issue_grant_oh,
    output logic                                 issue_ready,
    input  logic                                 resp_valid,
    input  logic [DATA_WIDTH-1:0]                resp_data,
    output logic                                 resp_ready,
    output logic [NUM_REQUESTERS-1:0]            req_resp_valid_oh,
    output logic [DATA_WIDTH-1:0]                req_resp_data,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_count,
    output logic                                 protocol_error,
    output logic                                 timeout
);

    localparam int IDX_W =
        (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

    if ((MAX_OUTSTANDING < 2) ||
        ((MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0))
    begin : g_bad_depth
        $error("MAX_OUTSTANDING must be a power of two >= 2");
    end

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // Lowest set bit wins, so a malformed grant still maps
    // to a defined requester (0 when no bit is set).
    function automatic logic [IDX_W-1:0] oh_to_idx(
        input logic [NUM_REQUESTERS-1:0] oh
    );
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
            if (oh[i]) idx = i[IDX_W-1:0];
        end
        return idx;
    endfunction

    function automatic logic [NUM_REQUESTERS-1:0] idx_to_oh(
        input logic [IDX_W-1:0] idx
    );
        logic [NUM_REQUESTERS-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [IDX_W-1:0] head_idx;
    logic             err_full;
    logic             err_empty;
    logic             err_grant;

    assign issue_ready = !full;
    assign resp_ready  = !empty;
    assign push        = issue_en && issue_ready;
    assign pop         = resp_valid && resp_ready;

    grant_id_fifo #(
        .WIDTH(IDX_W),
        .DEPTH(MAX_OUTSTANDING)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (oh_to_idx(issue_grant_oh)),
        .pop       (pop),
        .head      (head_idx),
        .full      (full),
        .empty     (empty),
        .count     (outstanding_count)
    );

    // Responses into an empty tracker are never matched with
    // a same-cycle issue; they are dropped and flagged.
    assign err_full  = issue_en && full;
    assign err_empty = resp_valid && empty;
    assign err_grant = issue_en && !$onehot(issue_grant_oh);

    always_ff @(posedge clk) begin
        if (reset) begin
            req_resp_valid_oh <= '0;
            req_resp_data     <= '0;
            protocol_error    <= 1'b0;
        end else begin
            req_resp_valid_oh <= pop ? idx_to_oh(head_idx) : '0;
            if (pop) req_resp_data <= resp_data;
            if (err_full || err_empty || err_grant)
                protocol_error <= 1'b1;
        end
    end

`ifdef RESP_ROUTER_TIMEOUT_EN
    localparam int AGE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT_CYCLES);

    logic [AGE_W-1:0] age;

    // Age of the oldest outstanding transaction since the
    // last response; saturates at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            age     <= '0;
            timeout <= 1'b0;
        end else begin
            if (pop || empty)
                age <= '0;
            else if (age != AGE_MAX)
                age <= age + 1'b1;
            if (age == AGE_MAX)
                timeout <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule
